// File: rtl/note_pkg.sv
// Shared note-word definitions for the song sequencer and the note ROM.
package note_pkg;

    localparam int unsigned NOTE_W   = 7;
    localparam int unsigned PITCH_W  = 4;
    localparam int unsigned DUR_W    = 3;
    localparam int unsigned ADDR_W   = 8;

    localparam int unsigned PITCH_HI = 6;
    localparam int unsigned PITCH_LO = 3;
    localparam int unsigned DUR_HI   = 2;
    localparam int unsigned DUR_LO   = 0;

    // A zero duration code marks the end of the song.
    localparam logic [DUR_W-1:0] DUR_END = 3'd0;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic note_t note_unpack(input logic [NOTE_W-1:0] word);
        note_t n;
        n.pitch = word[PITCH_HI:PITCH_LO];
        n.dur   = word[DUR_HI:DUR_LO];
        return n;
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, ROM read port and note-event bus between the sequencer and its consumers.
interface note_sequencer_if;
    import note_pkg::*;

    logic                start;
    logic                pause;
    logic [ADDR_W-1:0]   addr;
    logic [NOTE_W-1:0]   notes;
    logic                note_valid;
    logic [PITCH_W-1:0]  note_pitch;
    logic [DUR_W-1:0]    note_dur;
    logic                playing;
    logic                done;

    modport master (
        input  start, pause, notes,
        output addr, note_valid, note_pitch, note_dur, playing, done
    );

    modport slave (
        output start, pause, notes,
        input  addr, note_valid, note_pitch, note_dur, playing, done
    );

endinterface

// File: rtl/beat_timer.sv
// Loadable down-counter with hold and zero flag; stops at zero rather than wrapping.
module beat_timer #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             hold,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && !hold && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/note_sequencer.sv
// Song playback engine: walks the note ROM, emits one-cycle note events and
// holds each note for its duration, with pause and restart.
module note_sequencer
    import note_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 12_500_000,
    parameter int unsigned SONG_LEN    = 59,
    parameter int unsigned CNT_W       = 27
) (
    input  logic              clk,
    input  logic              rst,
    note_sequencer_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0]  TICK_CNT  = CNT_W'(TICK_CYCLES);

    seq_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [PITCH_W-1:0]  pitch_q, pitch_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                playing_q, done_q;
    // Set on expiry of the last note: one closing cycle stands in for the FETCH slot.
    logic                fin_q, fin_d;

    note_t               cur_c;
    logic                tmr_load_c;
    logic [CNT_W-1:0]    tmr_val_c;
    logic                tmr_zero_c;

    assign cur_c = note_unpack(bus.notes);

    beat_timer #(
        .CNT_W (CNT_W)
    ) u_beat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .en       (state_q == ST_PLAY),
        .hold     (bus.pause),
        .zero_c   (tmr_zero_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            pitch_q   <= '0;
            dur_q     <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            pitch_q   <= pitch_d;
            dur_q     <= dur_d;
            playing_q <= (state_d == ST_FETCH) || (state_d == ST_PLAY);
            done_q    <= (state_d == ST_DONE);
            fin_q     <= fin_d;
        end
    end

    // Next state; start overrides everything, including pause and expiry
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        pitch_d    = pitch_q;
        dur_d      = dur_q;
        fin_d      = fin_q;
        tmr_load_c = 1'b0;
        tmr_val_c  = (CNT_W'(cur_c.dur) * TICK_CNT) - CNT_W'(2);

        if (bus.start) begin
            state_d = ST_FETCH;
            addr_d  = '0;
            fin_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_FETCH: begin
                    if (cur_c.dur == DUR_END) begin
                        state_d = ST_DONE;
                    end else begin
                        pitch_d    = cur_c.pitch;
                        dur_d      = cur_c.dur;
                        valid_d    = 1'b1;
                        tmr_load_c = 1'b1;
                        state_d    = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (fin_q) begin
                        state_d = ST_DONE;
                        fin_d   = 1'b0;
                    end else if (!bus.pause && tmr_zero_c) begin
                        if (addr_q == LAST_ADDR) begin
                            fin_d = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.addr       = addr_q;
    assign bus.note_valid = valid_q;
    assign bus.note_pitch = pitch_q;
    assign bus.note_dur   = dur_q;
    assign bus.playing    = playing_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed timing scenarios plus random ROM/start/pause
// traffic checked cycle by cycle against a note-schedule model.
module tb_note_sequencer;

    localparam int unsigned TICK = 4;
    localparam int unsigned SLEN = 2;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_PLAY  = 2;
    localparam int M_TAIL  = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] rom [0:255];

    note_sequencer_if bus();

    note_sequencer #(
        .TICK_CYCLES (TICK),
        .SONG_LEN    (SLEN),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.notes = rom[bus.addr];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model: which slot of the song we are in and how many unpaused play cycles remain
    int         m_mode;
    int         m_idx;
    int         m_left;
    logic       m_valid;
    logic [3:0] m_pitch;
    logic [2:0] m_dur;

    int   vq[$];
    int   pq[$];
    int   done_at;
    logic done_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int qget(input int i);
        if (i < vq.size()) return vq[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_idx   = 0;
        m_left  = 0;
        m_valid = 1'b0;
        m_pitch = '0;
        m_dur   = '0;
    endtask

    task automatic model_step(input logic s, input logic p);
        logic [6:0] w;
        m_valid = 1'b0;
        if (s) begin
            m_mode = M_FETCH;
            m_idx  = 0;
        end else begin
            case (m_mode)
                M_FETCH: begin
                    w = rom[m_idx];
                    if (w[2:0] == 3'd0) begin
                        m_mode = M_DONE;
                    end else begin
                        m_pitch = w[6:3];
                        m_dur   = w[2:0];
                        m_valid = 1'b1;
                        m_left  = int'(m_dur) * int'(TICK) - 1;
                        m_mode  = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (!p) begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_idx == int'(SLEN) - 1) begin
                                m_mode = M_TAIL;
                            end else begin
                                m_idx++;
                                m_mode = M_FETCH;
                            end
                        end
                    end
                end
                M_TAIL: m_mode = M_DONE;
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("addr",       32'(bus.addr),       32'(m_idx));
        check("note_valid", 32'(bus.note_valid), 32'(m_valid));
        check("note_pitch", 32'(bus.note_pitch), 32'(m_pitch));
        check("note_dur",   32'(bus.note_dur),   32'(m_dur));
        check("playing",    32'(bus.playing),
              32'(m_mode == M_FETCH || m_mode == M_PLAY || m_mode == M_TAIL));
        check("done",       32'(bus.done),       32'(m_mode == M_DONE));
    endtask

    task automatic begin_run();
        cyc       = 0;
        done_at   = -1;
        done_prev = bus.done;
        vq.delete();
        pq.delete();
    endtask

    // Drive one cycle's inputs, step the model on the edge, compare mid-cycle
    task automatic tick(input logic s, input logic p);
        bus.start = s;
        bus.pause = p;
        @(posedge clk);
        model_step(s, p);
        @(negedge clk);
        cyc++;
        compare_all();
        if (bus.note_valid === 1'b1) begin
            vq.push_back(cyc);
            pq.push_back(int'(bus.note_pitch));
        end
        if (bus.done === 1'b1 && done_prev !== 1'b1 && done_at < 0) done_at = cyc;
        done_prev = bus.done;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 7'b0000_000;
        rom[0] = 7'b0000_010;
        rom[1] = 7'b0011_100;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Basic run
        begin_run();
        tick(1'b1, 1'b0);
        repeat (29) tick(1'b0, 1'b0);
        check("basic_events", 32'(vq.size()), 32'd2);
        check("basic_v0",     32'(qget(0)),   32'd2);
        check("basic_v1",     32'(qget(1)),   32'd10);
        check("basic_done",   32'(done_at),   32'd26);

        // Pause during the first note
        begin_run();
        for (int c = 0; c < 35; c++) tick(c == 0, (c >= 4) && (c <= 8));
        check("pause_events", 32'(vq.size()), 32'd2);
        check("pause_v0",     32'(qget(0)),   32'd2);
        check("pause_v1",     32'(qget(1)),   32'd15);
        check("pause_done",   32'(done_at),   32'd31);

        // Terminator in the second slot
        rom[1] = 7'b0011_000;
        begin_run();
        tick(1'b1, 1'b0);
        repeat (19) tick(1'b0, 1'b0);
        check("term_events", 32'(vq.size()), 32'd1);
        check("term_v0",     32'(qget(0)),   32'd2);
        check("term_done",   32'(done_at),   32'd10);
        rom[1] = 7'b0011_100;

        // Restart mid second note
        begin_run();
        for (int c = 0; c < 24; c++) begin
            tick((c == 0) || (c == 12), 1'b0);
            if (cyc == 13) check("restart_addr13", 32'(bus.addr), 32'd0);
        end
        check("restart_events", 32'(vq.size()), 32'd4);
        check("restart_v2",     32'(qget(2)),   32'd14);
        check("restart_p2",     32'((pq.size() > 2) ? pq[2] : -1), 32'd0);
        check("restart_v3",     32'(qget(3)),   32'd22);

        // Start together with pause mid-PLAY
        begin_run();
        for (int c = 0; c < 12; c++) tick((c == 0) || (c == 5), c == 5);
        check("startpause_v1", 32'(qget(1)), 32'd7);

        // Asynchronous reset between edges
        begin_run();
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_playing", 32'(bus.playing),    32'd0);
        check("arst_pitch",   32'(bus.note_pitch), 32'd0);
        check("arst_dur",     32'(bus.note_dur),   32'd0);
        compare_all();
        #1;
        rst = 1'b0;
        @(negedge clk);
        repeat (10) tick(1'b0, 1'b0);

        // Random ROM contents, start pulses and pause
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < int'(SLEN); i++) begin
                rom[i][6:3] = 4'($urandom_range(0, 15));
                rom[i][2:0] = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            end
            begin_run();
            for (int c = 0; c < 160; c++)
                tick((c == 0) || ($urandom_range(0, 39) == 0), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
